// File: rtl/cam_sccb_config.sv
// OV7670 power-up sequencer: walks a fixed register table and issues each entry
// as a 3-phase SCCB write (device ID, register, value) on SIOC / open-drain SIOD.
module cam_sccb_config #(
  parameter int         QUARTER   = 250,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         DELAY_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       sioc,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic [2:0] cfg_index
);

  localparam int TW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int DW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [1:0]    qtr, qtr_n;
  logic [4:0]    bidx, bidx_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [2:0]    idx_n;
  logic          busy_n, done_n, sioc_n, oe_n;
  logic          q_end, phase_end;

  function automatic logic [15:0] entry(input logic [2:0] i);
    case (i)
      3'd0:    entry = 16'h1280;
      3'd1:    entry = 16'h1204;
      3'd2:    entry = 16'h40D0;
      3'd3:    entry = 16'h8C02;
      3'd4:    entry = 16'h0C04;
      default: entry = 16'h3E1A;
    endcase
  endfunction

  // Don't-care (ack) slots carry a 1 so SIOD is released there.
  function automatic logic [26:0] frame(input logic [2:0] i);
    logic [15:0] e;
    e = entry(i);
    frame = {DEV_ADDR, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
  endfunction

  // Returns {sioc, siod_oe} for a given position in the write.
  function automatic logic [1:0] lines(input state_t st, input logic [1:0] q,
                                       input logic [4:0] b, input logic [2:0] i);
    logic [26:0] f;
    f = frame(i);
    case (st)
      S_START: lines = {1'b1, q[1]};
      S_BIT:   lines = {q[1], ~f[5'd26 - b]};
      S_STOP:  lines = {q != 2'd0, ~q[1]};
      default: lines = 2'b10;
    endcase
  endfunction

  assign q_end     = (tcnt == TW'(QUARTER - 1));
  assign phase_end = q_end && (qtr == 2'd3);

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    qtr_n   = qtr;
    bidx_n  = bidx;
    dcnt_n  = dcnt;
    idx_n   = cfg_index;
    busy_n  = busy;
    done_n  = done;

    if (state == S_START || state == S_BIT || state == S_STOP || state == S_GAP) begin
      if (q_end) begin
        tcnt_n = '0;
        qtr_n  = qtr + 2'd1;
      end else begin
        tcnt_n = tcnt + TW'(1);
      end
    end

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_START;
          idx_n   = 3'd0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          tcnt_n  = '0;
          qtr_n   = 2'd0;
          bidx_n  = 5'd0;
        end
      end
      S_START: if (phase_end) begin
        state_n = S_BIT;
        bidx_n  = 5'd0;
      end
      S_BIT: if (phase_end) begin
        if (bidx == 5'd26) state_n = S_STOP;
        else               bidx_n  = bidx + 5'd1;
      end
      S_STOP: if (phase_end) state_n = S_GAP;
      S_GAP: if (phase_end) begin
        // Entry 0 is the soft reset; the sensor needs settle time before the rest.
        if (cfg_index == 3'd0) begin
          state_n = S_DELAY;
          dcnt_n  = '0;
        end else if (cfg_index < 3'd5) begin
          idx_n   = cfg_index + 3'd1;
          state_n = S_START;
        end else begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      S_DELAY: begin
        if (dcnt == DW'(DELAY_CYC - 1)) begin
          state_n = S_START;
          idx_n   = 3'd1;
          tcnt_n  = '0;
          qtr_n   = 2'd0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    {sioc_n, oe_n} = lines(state_n, qtr_n, bidx_n, idx_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      qtr       <= 2'd0;
      bidx      <= 5'd0;
      dcnt      <= '0;
      cfg_index <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sioc      <= 1'b1;
      siod_oe   <= 1'b0;
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      qtr       <= qtr_n;
      bidx      <= bidx_n;
      dcnt      <= dcnt_n;
      cfg_index <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
      sioc      <= sioc_n;
      siod_oe   <= oe_n;
    end
  end

endmodule

// File: tb/tb_cam_sccb_config.sv
// Bench for cam_sccb_config: SCCB line decoder, transaction-level busy/done/index
// model, and directed runs (plain, restart from done, ignored starts, mid-write reset).
module tb_cam_sccb_config;

  localparam int Q     = 4;
  localparam int DLY   = 40;
  localparam int WRITE = 30 * 4 * Q;
  localparam int TOTAL = 6 * WRITE + DLY;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sioc, siod_oe, busy, done;
  logic [2:0] cfg_index;

  cam_sccb_config #(.QUARTER(Q), .DEV_ADDR(8'h42), .DELAY_CYC(DLY)) dut (
    .clk(clk), .rst(rst), .start(start), .sioc(sioc), .siod_oe(siod_oe),
    .busy(busy), .done(done), .cfg_index(cfg_index)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  logic [7:0] exp_reg [6] = '{8'h12, 8'h12, 8'h40, 8'h8C, 8'h0C, 8'h3E};
  logic [7:0] exp_val [6] = '{8'h80, 8'h04, 8'hD0, 8'h02, 8'h04, 8'h1A};

  longint cyc = 0;
  always @(posedge clk) cyc++;

  // SCCB decoder working on the open-drain level seen by the sensor.
  logic [27:0]  sh;
  int           mcnt = 0;
  logic         p_sioc = 1'b1, p_sd = 1'b1, sd;
  logic [26:0]  frames[$];
  longint       starts_q[$];

  always @(negedge clk) begin
    sd = ~siod_oe;
    if (!p_sioc && sioc) begin
      sh = {sh[26:0], sd};
      mcnt++;
    end else if (p_sioc && sioc) begin
      if (p_sd && !sd) begin
        mcnt = 0;
        starts_q.push_back(cyc);
      end else if (!p_sd && sd && mcnt == 28) begin
        frames.push_back(sh[27:1]);
      end
    end
    p_sioc = sioc;
    p_sd   = sd;
  end

  // Transaction-level model: busy lasts TOTAL cycles from acceptance; the index
  // follows from elapsed time (entry 0, then the delay, then 480-cycle writes).
  logic m_busy = 1'b0, m_done = 1'b0;
  int   m_el = 0;
  logic [2:0] m_idx;
  logic p_done = 1'b0;
  int   done_rises = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_el = 0;
    end else if (m_busy) begin
      m_el++;
      if (m_el == TOTAL) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end else if (start) begin
      m_busy = 1'b1; m_done = 1'b0; m_el = 0;
    end
  end

  always @(negedge clk) begin
    if (m_el < WRITE + DLY) m_idx = 3'd0;
    else if (1 + (m_el - WRITE - DLY) / WRITE > 5) m_idx = 3'd5;
    else m_idx = 3'(1 + (m_el - WRITE - DLY) / WRITE);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("cfg_index", cfg_index, m_idx);
    if (!busy) chk("idle_lines", {sioc, siod_oe}, 2'b10);
    if (done && !p_done) begin
      done_rises++;
      chk("busy_falls_with_done", busy, 1'b0);
    end
    p_done = done;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_seq(input int extra_starts);
    int n;
    frames.delete();
    starts_q.delete();
    done_rises = 0;
    pulse_start();
    chk("accept", {busy, done, cfg_index}, {1'b1, 1'b0, 3'd0});
    for (int i = 0; i < extra_starts; i++) begin
      repeat (300) @(negedge clk);
      pulse_start();
    end
    n = 0;
    while (busy && n < 2 * TOTAL) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("write_count", frames.size(), 6);
    for (int i = 0; i < frames.size() && i < 6; i++) begin
      chk($sformatf("dev[%0d]", i), frames[i][26:19], 8'h42);
      chk($sformatf("reg[%0d]", i), frames[i][17:10], exp_reg[i]);
      chk($sformatf("val[%0d]", i), frames[i][8:1], exp_val[i]);
      chk($sformatf("ack_released[%0d]", i), {frames[i][18], frames[i][9], frames[i][0]}, 3'b111);
    end
    chk("start_count", starts_q.size(), 6);
    if (starts_q.size() >= 2)
      chk_range("gap_first", starts_q[1] - starts_q[0], WRITE + DLY - 1, WRITE + DLY + 1);
    for (int i = 2; i < starts_q.size(); i++)
      chk_range($sformatf("gap[%0d]", i), starts_q[i] - starts_q[i-1], WRITE, WRITE);
    chk("done_rises", done_rises, 1);
    chk("done_held", {done, busy}, 2'b10);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {sioc, siod_oe, busy, done, cfg_index}, {4'b1000, 3'd0});
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_seq(0);   // plain run from IDLE
    run_seq(0);   // restart from DONE
    run_seq(5);   // starts while busy are ignored

    // Abort in the middle of entry 3, bit 10.
    pulse_start();
    n = 0;
    while (!(cfg_index == 3'd3 && mcnt == 10) && n < 2 * TOTAL) begin
      @(negedge clk);
      n++;
    end
    chk("reach_entry3_bit10", {cfg_index, 4'(mcnt)}, {3'd3, 4'd10});
    #1 rst = 1'b0;
    #1 chk("async_abort", {sioc, siod_oe, busy}, 3'b100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_seq(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
